mac_seq_ctrl: RTL and testbench

- Sequencer for one mac_int8 instance: runs a dot-product job of LEN weight/activation pairs plus a 32-bit bias.
- Pulls operand pairs from a valid/ready stream and issues each pair to the MAC.
- Feeds the MAC's acc_out back as the next acc_in, then presents the final sum on a valid/ready result port.
- Sits between the operand fetch logic and the post-processing/write-back stage of the DPU.

---
 rtl/mac_seq_pkg.sv | 17 +
 rtl/mac_seq_ctrl.sv | 154 +++++++++++++++
 tb/tb_mac_seq_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/mac_seq_pkg.sv
// Shared types and default widths for the MAC job sequencer.
package mac_seq_pkg;

  // Controller states; 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    RESULT = 2'd3
  } state_e;

  localparam int ACC_W_DEF = 32;
  localparam int LEN_W_DEF = 16;

  typedef logic signed [31:0] acc_t;

endpackage

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequences a LEN-pair dot-product job through one mac_int8.
// Operand pairs are pulled from a valid/ready stream, issued one at a time,
// and the MAC result is fed back as the next running sum. The final sum is
// offered on a valid/ready result port.
// Optional build macro MAC_SEQ_CTRL_RELU_EN clamps negative final sums to 0
// (applies to the len==0 bias-only path too).
module mac_seq_ctrl
  import mac_seq_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LEN_W-1:0]        len,
  input  logic signed [ACC_W-1:0] bias,
  output logic                    busy,
  input  logic                    op_valid,
  output logic                    op_ready,
  input  logic signed [7:0]       op_weight,
  input  logic signed [7:0]       op_act,
  output logic                    mac_valid,
  output logic signed [7:0]       mac_weight,
  output logic signed [7:0]       mac_act,
  output logic signed [ACC_W-1:0] mac_acc_in,
  input  logic signed [ACC_W-1:0] mac_acc_out,
  input  logic                    mac_done,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic signed [ACC_W-1:0] res_data
);

  state_e                  state_q, state_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic [LEN_W-1:0]        cnt_q, cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    busy_q, busy_d;
  logic                    mac_valid_q, mac_valid_d;
  logic signed [7:0]       mac_weight_q, mac_weight_d;
  logic signed [7:0]       mac_act_q, mac_act_d;
  logic signed [ACC_W-1:0] mac_acc_in_q, mac_acc_in_d;
  logic                    res_valid_q, res_valid_d;
  logic signed [ACC_W-1:0] res_data_q, res_data_d;

  // Final-sum post-processing applied on every entry to RESULT.
  function automatic logic signed [ACC_W-1:0] post(input logic signed [ACC_W-1:0] s);
`ifdef MAC_SEQ_CTRL_RELU_EN
    return s[ACC_W-1] ? '0 : s;
`else
    return s;
`endif
  endfunction

  // Next-state and registered-output logic for the job FSM.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    mac_valid_d  = 1'b0;
    mac_weight_d = mac_weight_q;
    mac_act_d    = mac_act_q;
    mac_acc_in_d = mac_acc_in_q;
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          len_d = len;
          acc_d = bias;
          cnt_d = '0;
          if (len == '0) begin
            res_valid_d = 1'b1;
            res_data_d  = post(bias);
            state_d     = RESULT;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (op_valid) begin
          mac_valid_d  = 1'b1;
          mac_weight_d = op_weight;
          mac_act_d    = op_act;
          mac_acc_in_d = acc_q;
          state_d      = WAIT;
        end
      end
      WAIT: begin
        if (mac_done) begin
          acc_d = mac_acc_out;
          cnt_d = cnt_q + LEN_W'(1);
          // len_q is never 0 here, so len_q-1 cannot underflow.
          if (cnt_q == len_q - LEN_W'(1)) begin
            res_valid_d = 1'b1;
            res_data_d  = post(mac_acc_out);
            state_d     = RESULT;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      RESULT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers; reset aborts any job at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      len_q        <= '0;
      cnt_q        <= '0;
      acc_q        <= '0;
      busy_q       <= 1'b0;
      mac_valid_q  <= 1'b0;
      mac_weight_q <= '0;
      mac_act_q    <= '0;
      mac_acc_in_q <= '0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      busy_q       <= busy_d;
      mac_valid_q  <= mac_valid_d;
      mac_weight_q <= mac_weight_d;
      mac_act_q    <= mac_act_d;
      mac_acc_in_q <= mac_acc_in_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
    end
  end

  assign op_ready   = (state_q == ISSUE);
  assign busy       = busy_q;
  assign mac_valid  = mac_valid_q;
  assign mac_weight = mac_weight_q;
  assign mac_act    = mac_act_q;
  assign mac_acc_in = mac_acc_in_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl paired with a behavioural 1-cycle MAC stand-in.
module tb_mac_seq_ctrl;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [15:0]        len;
  logic signed [31:0] bias;
  logic               busy;
  logic               op_valid;
  logic               op_ready;
  logic signed [7:0]  op_weight, op_act;
  logic               mac_valid;
  logic signed [7:0]  mac_weight, mac_act;
  logic signed [31:0] mac_acc_in, mac_acc_out;
  logic               mac_done;
  logic               res_valid, res_ready;
  logic signed [31:0] res_data;

  // MAC stand-in: answers in the issue cycle unless stalled; inject forces a stray result.
  logic mac_stall = 1'b0;
  logic inject    = 1'b0;
  assign mac_done    = (mac_valid & ~mac_stall) | inject;
  assign mac_acc_out = inject ? 32'sh0BADF00D : mac_acc_in + mac_weight * mac_act;

  mac_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .bias(bias), .busy(busy),
    .op_valid(op_valid), .op_ready(op_ready), .op_weight(op_weight), .op_act(op_act),
    .mac_valid(mac_valid), .mac_weight(mac_weight), .mac_act(mac_act),
    .mac_acc_in(mac_acc_in), .mac_acc_out(mac_acc_out), .mac_done(mac_done),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  byte pw[$];
  byte pa[$];
  byte iss_w[$];
  byte iss_a[$];
  int  iss_acc[$];

  // Record every issue pulse seen on the MAC side.
  always @(negedge clk) begin
    if (mac_valid) begin
      iss_w.push_back(mac_weight);
      iss_a.push_back(mac_act);
      iss_acc.push_back(mac_acc_in);
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Golden dot product: bias plus sum of products, 32-bit wrap, optional clamp.
  function automatic int model(input int ln, input int bs);
    int s;
    s = bs;
    for (int i = 0; i < ln; i++) s += int'(pw[i]) * int'(pa[i]);
`ifdef MAC_SEQ_CTRL_RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  // Run one job using pairs in pw/pa. gap = % of cycles with op_valid low,
  // rrd = cycles res_ready stays low after res_valid.
  task automatic run_job(input int ln, input int bs, input int gap, input int rrd,
                         input bit chk_lat, input int exp_lat, input string tag);
    int idx, cyc, hold, lat, s;
    bit got, done;
    logic signed [31:0] held;
    idx = 0; got = 0; done = 0; lat = -1; hold = 0; held = '0;
    iss_w.delete(); iss_a.delete(); iss_acc.delete();
    start = 1'b1; len = ln[15:0]; bias = bs;
    @(posedge clk); #1;
    start = 1'b0; bias = $urandom; cyc = 1;
    while (!done && cyc < 500) begin
      if (idx < ln && int'($urandom_range(99)) >= gap) begin
        op_valid = 1'b1; op_weight = pw[idx]; op_act = pa[idx];
      end else begin
        op_valid = 1'b0; op_weight = $urandom; op_act = $urandom;
      end
      // Stray start pulses while busy must be ignored.
      if (gap > 0 || rrd > 0) start = $urandom_range(1);
      @(negedge clk);
      if (op_valid && op_ready) idx++;
      if (res_valid) begin
        if (!got) begin
          got = 1; lat = cyc; held = res_data; hold = rrd;
        end else begin
          chk({tag, " res_data stable"}, res_data, held);
        end
        if (hold == 0) begin
          res_ready = 1'b1; start = 1'b1; done = 1;
        end else begin
          hold--;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    res_ready = 1'b0; start = 1'b0; op_valid = 1'b0;
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL %s timeout: got no result handshake expected one within 500 cycles", tag);
    end else begin
      chk({tag, " res_data"}, held, model(ln, bs));
      chk({tag, " mac pulses"}, iss_w.size(), ln);
      s = bs;
      for (int i = 0; i < ln && i < iss_w.size(); i++) begin
        chk({tag, " pair w"}, iss_w[i], pw[i]);
        chk({tag, " pair a"}, iss_a[i], pa[i]);
        chk({tag, " acc_in"}, iss_acc[i], s);
        s += int'(pw[i]) * int'(pa[i]);
      end
      chk({tag, " idle after handshake"}, {busy, res_valid}, 0);
      if (chk_lat) chk({tag, " latency"}, lat, exp_lat);
      @(posedge clk); #1;
      chk({tag, " no restart"}, busy, 0);
    end
  endtask

  typedef struct {
    int ln; int bs;
    int w0; int a0; int w1; int a1; int w2; int a2;
    int exp_raw; int exp_relu; int lat;
  } vec_t;

  vec_t vt[5];

  initial begin
    int ln, exp;
    vt[0] = '{1, 0,    10, 20,   0,  0,   0,   0,   200,   200, 3};
    vt[1] = '{3, 0,    10, 20, -10, 20, 127, 127, 16129, 16129, 7};
    vt[2] = '{1, 1000, 50, 50,   0,  0,   0,   0,  3500,  3500, 3};
    vt[3] = '{0, -7,    0,  0,   0,  0,   0,   0,    -7,     0, 1};
    vt[4] = '{1, 0,   -10, 20,   0,  0,   0,   0,  -200,     0, 3};

    rst = 1'b1; start = 1'b0; len = '0; bias = '0; op_valid = 1'b0;
    op_weight = '0; op_act = '0; res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset outputs", |{busy, op_ready, mac_valid, mac_weight, mac_act,
                          mac_acc_in, res_valid, res_data}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed table: check against hand-computed sums and latency.
    for (int v = 0; v < 5; v++) begin
      pw.delete(); pa.delete();
      pw.push_back(byte'(vt[v].w0)); pa.push_back(byte'(vt[v].a0));
      pw.push_back(byte'(vt[v].w1)); pa.push_back(byte'(vt[v].a1));
      pw.push_back(byte'(vt[v].w2)); pa.push_back(byte'(vt[v].a2));
`ifdef MAC_SEQ_CTRL_RELU_EN
      exp = vt[v].exp_relu;
`else
      exp = vt[v].exp_raw;
`endif
      chk($sformatf("vec%0d const", v), model(vt[v].ln, vt[v].bs), exp);
      run_job(vt[v].ln, vt[v].bs, 0, 0, 1'b1, vt[v].lat, $sformatf("vec%0d", v));
    end

    // Backpressure on both sides: operand gaps and 5-cycle result stall.
    pw.delete(); pa.delete();
    for (int i = 0; i < 5; i++) begin
      pw.push_back(byte'($urandom)); pa.push_back(byte'($urandom));
    end
    run_job(5, 123, 50, 5, 1'b0, 0, "bp");

    // Reset while parked in WAIT, then a stray MAC result after release.
    pw.delete(); pa.delete();
    pw.push_back(8'sd1); pa.push_back(8'sd2);
    mac_stall = 1'b1;
    start = 1'b1; len = 16'd4; bias = 32'sd0;
    @(posedge clk); #1;
    start = 1'b0; op_valid = 1'b1; op_weight = 8'sd1; op_act = 8'sd2;
    @(posedge clk); #1;
    op_valid = 1'b0;
    chk("wait mac_valid pulse", mac_valid, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("wait holds busy", busy, 1);
    chk("wait mac_valid one cycle", mac_valid, 0);
    chk("wait op_ready low", op_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async reset outputs", |{busy, op_ready, mac_valid, mac_weight, mac_act,
                                mac_acc_in, res_valid, res_data}, 0);
    @(posedge clk); #1;
    rst = 1'b0; mac_stall = 1'b0; inject = 1'b1;
    @(posedge clk); #1;
    inject = 1'b0;
    chk("late mac_done ignored", {busy, res_valid}, 0);
    pw.delete(); pa.delete();
    pw.push_back(8'sd2); pa.push_back(8'sd3);
    chk("post-reset model", model(1, 0), 6);
    run_job(1, 0, 0, 0, 1'b1, 3, "post-reset");

    // Randomized jobs against the golden model.
    for (int t = 0; t < 20; t++) begin
      ln = $urandom_range(0, 8);
      pw.delete(); pa.delete();
      for (int i = 0; i < ln; i++) begin
        pw.push_back(byte'($urandom)); pa.push_back(byte'($urandom));
      end
      run_job(ln, int'($urandom), $urandom_range(0, 60), $urandom_range(0, 3),
              1'b0, 0, $sformatf("rnd%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
